// File: rtl/hd44780_ctrl_if.sv
// rtl/hd44780_ctrl_if.sv - host write port of the HD44780 controller
// Valid/ready byte port: the host drives rs/data/valid, the controller answers with ready.
interface hd44780_ctrl_if;
   logic       wr_valid;
   logic       wr_ready;
   logic       wr_rs;
   logic [7:0] wr_data;

   modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/hd44780_ctrl.sv
// rtl/hd44780_ctrl.sv - parametrised write-only HD44780 character-LCD controller
// Runs the power-on init sequence, then forwards host instruction/data bytes to the
// panel on an 8-bit or 4-bit bus while tracking the cursor for automatic line wrap.
module hd44780_ctrl #(
   parameter int CLK_KHZ   = 1000,
   parameter int BUS_WIDTH = 8,
   parameter int ROWS      = 2,
   parameter int COLS      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hd44780_ctrl_if.slave        wr,
   output logic                 init_done,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_e,
   output logic [BUS_WIDTH-1:0] lcd_data
);
   localparam int US = CLK_KHZ / 1000;

   localparam logic [23:0] T_US    = 24'(US);
   localparam logic [23:0] T_PWRUP = 24'(15000 * US);
   localparam logic [23:0] T_4100  = 24'(4100 * US);
   localparam logic [23:0] T_1640  = 24'(1640 * US);
   localparam logic [23:0] T_100   = 24'(100 * US);
   localparam logic [23:0] T_40    = 24'(40 * US);

   // DL follows the bus width, N is cleared only for single-row panels
   localparam logic [7:0] FUNC_SET = ((BUS_WIDTH == 8) ? 8'h30 : 8'h20) |
                                     ((ROWS == 1) ? 8'h00 : 8'h08);
   localparam logic [3:0] LAST_STEP = 4'd8;
   localparam logic [1:0] LAST_ROW  = 2'(ROWS - 1);
   localparam logic [4:0] COLS_W    = 5'(COLS);

   typedef enum logic [2:0] {
      S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_E_HI, S_E_LO, S_WAIT, S_WRAP
   } state_t;

   state_t      state;
   logic [23:0] cnt;
   logic [3:0]  step;
   logic [7:0]  cur_byte;
   logic        low_nib;
   logic        two_nib;
   logic [23:0] post_wait;
   logic [1:0]  row;
   logic [4:0]  col;
   logic        track_ok;
   logic        wrap_pend;
   logic        ready_q;

   logic [7:0]  init_byte;
   logic        init_nib;
   logic [23:0] init_wait;
   logic [23:0] host_wait;
   logic        clr_home;
   logic        dd_hit;
   logic [1:0]  dd_row;
   logic [4:0]  dd_col;
   logic [1:0]  wrap_row;

   function automatic logic [6:0] row_off(input logic [1:0] r);
      case (r)
         2'd0:    return 7'h00;
         2'd1:    return 7'h40;
         2'd2:    return 7'h14;
         default: return 7'h54;
      endcase
   endfunction

   // Pins value for one bus cycle: whole byte, or the selected nibble on D7..D4
   function automatic logic [BUS_WIDTH-1:0] bus_val(input logic [7:0] b, input logic lo);
      logic [7:0] v;
      if (BUS_WIDTH == 8) v = b;
      else v = lo ? {4'h0, b[3:0]} : {4'h0, b[7:4]};
      return v[BUS_WIDTH-1:0];
   endfunction

   assign lcd_rw      = 1'b0;
   assign wr.wr_ready = ready_q;
   assign wrap_row    = (row == LAST_ROW) ? 2'd0 : row + 2'd1;

   // Init step table; step 3 (the 0x2 nibble) is skipped on an 8-bit bus
   always_comb begin
      init_byte = 8'h30;
      init_nib  = 1'b1;
      init_wait = T_40;
      case (step)
         4'd0: init_wait = T_4100;
         4'd1: init_wait = T_100;
         4'd2: init_wait = T_40;
         4'd3: init_byte = 8'h20;
         4'd4: begin init_byte = FUNC_SET; init_nib = 1'b0; end
         4'd5: begin init_byte = 8'h08;    init_nib = 1'b0; end
         4'd6: begin init_byte = 8'h01;    init_nib = 1'b0; init_wait = T_1640; end
         4'd7: begin init_byte = 8'h06;    init_nib = 1'b0; end
         default: begin init_byte = 8'h0C; init_nib = 1'b0; end
      endcase
   end

   // Decode the offered host byte: post-write wait and set-DDRAM row/column lookup
   always_comb begin
      clr_home  = !wr.wr_rs && (wr.wr_data[7:2] == 6'd0) && (wr.wr_data[1:0] != 2'd0);
      host_wait = clr_home ? T_1640 : T_40;
      dd_hit    = 1'b0;
      dd_row    = 2'd0;
      dd_col    = 5'd0;
      for (int r = 0; r < ROWS; r++) begin
         if (wr.wr_data[6:0] >= row_off(2'(r)) &&
             wr.wr_data[6:0] < row_off(2'(r)) + 7'(COLS)) begin
            dd_hit = 1'b1;
            dd_row = 2'(r);
            dd_col = 5'(wr.wr_data[6:0] - row_off(2'(r)));
         end
      end
   end

   // Main sequencer: init, host handshake, bus timing, cursor tracking and wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_PWRUP;
         cnt       <= T_PWRUP - 24'd1;
         step      <= 4'd0;
         cur_byte  <= 8'h00;
         low_nib   <= 1'b0;
         two_nib   <= 1'b0;
         post_wait <= T_40;
         row       <= 2'd0;
         col       <= 5'd0;
         track_ok  <= 1'b1;
         wrap_pend <= 1'b0;
         ready_q   <= 1'b0;
         init_done <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_data  <= '0;
      end else begin
         case (state)
            S_PWRUP: begin
               if (cnt == 24'd0) state <= S_INIT;
               else cnt <= cnt - 24'd1;
            end
            S_INIT: begin
               cur_byte  <= init_byte;
               lcd_rs    <= 1'b0;
               low_nib   <= 1'b0;
               two_nib   <= (BUS_WIDTH == 4) && !init_nib;
               post_wait <= init_wait;
               lcd_data  <= bus_val(init_byte, 1'b0);
               cnt       <= T_US - 24'd1;
               state     <= S_SETUP;
            end
            S_IDLE: begin
               if (wr.wr_valid && ready_q) begin
                  ready_q   <= 1'b0;
                  cur_byte  <= wr.wr_data;
                  lcd_rs    <= wr.wr_rs;
                  low_nib   <= 1'b0;
                  two_nib   <= (BUS_WIDTH == 4);
                  post_wait <= host_wait;
                  lcd_data  <= bus_val(wr.wr_data, 1'b0);
                  cnt       <= T_US - 24'd1;
                  state     <= S_SETUP;
                  if (wr.wr_rs) begin
                     if (track_ok) begin
                        col <= col + 5'd1;
                        if (col + 5'd1 == COLS_W) wrap_pend <= 1'b1;
                     end
                  end else if (clr_home) begin
                     row      <= 2'd0;
                     col      <= 5'd0;
                     track_ok <= 1'b1;
                  end else if (wr.wr_data[7]) begin
                     if (dd_hit) begin
                        row      <= dd_row;
                        col      <= dd_col;
                        track_ok <= 1'b1;
                     end else begin
                        track_ok <= 1'b0;
                     end
                  end
               end
            end
            S_SETUP: begin
               if (cnt == 24'd0) begin
                  lcd_e <= 1'b1;
                  cnt   <= T_US - 24'd1;
                  state <= S_E_HI;
               end else cnt <= cnt - 24'd1;
            end
            S_E_HI: begin
               if (cnt == 24'd0) begin
                  lcd_e <= 1'b0;
                  cnt   <= T_US - 24'd1;
                  state <= S_E_LO;
               end else cnt <= cnt - 24'd1;
            end
            S_E_LO: begin
               // the post-write wait is measured from the E fall, so the hold counts toward it
               if (cnt == 24'd0) begin
                  if (two_nib && !low_nib) begin
                     low_nib  <= 1'b1;
                     lcd_data <= bus_val(cur_byte, 1'b1);
                     cnt      <= T_US - 24'd1;
                     state    <= S_SETUP;
                  end else begin
                     cnt   <= post_wait - T_US - 24'd1;
                     state <= S_WAIT;
                  end
               end else cnt <= cnt - 24'd1;
            end
            S_WAIT: begin
               if (cnt == 24'd0) begin
                  if (!init_done) begin
                     if (step == LAST_STEP) begin
                        init_done <= 1'b1;
                        ready_q   <= 1'b1;
                        state     <= S_IDLE;
                     end else begin
                        step  <= (BUS_WIDTH == 8 && step == 4'd2) ? 4'd4 : step + 4'd1;
                        state <= S_INIT;
                     end
                  end else if (wrap_pend) begin
                     state <= S_WRAP;
                  end else begin
                     ready_q <= 1'b1;
                     state   <= S_IDLE;
                  end
               end else cnt <= cnt - 24'd1;
            end
            S_WRAP: begin
               cur_byte  <= {1'b1, row_off(wrap_row)};
               lcd_rs    <= 1'b0;
               low_nib   <= 1'b0;
               two_nib   <= (BUS_WIDTH == 4);
               post_wait <= T_40;
               lcd_data  <= bus_val({1'b1, row_off(wrap_row)}, 1'b0);
               cnt       <= T_US - 24'd1;
               row       <= wrap_row;
               col       <= 5'd0;
               wrap_pend <= 1'b0;
               state     <= S_SETUP;
            end
            default: state <= S_PWRUP;
         endcase
      end
   end
endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb/tb_hd44780_ctrl.sv - directed self-checking bench for hd44780_ctrl
module tb_hd44780_ctrl;
   logic       clk = 1'b0;
   logic       clk4 = 1'b0;
   logic       clk4_on = 1'b1;
   logic       rst_n;
   logic       rst_n2;
   logic       init_done, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;
   logic       init_done2, lcd_rs2, lcd_rw2, lcd_e2;
   logic [3:0] lcd_data2;

   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         rise_cyc = 0;
   int         fall_cyc = 0;
   logic       e_prev = 1'b0;
   logic [8:0] cap_q[$];
   logic [7:0] init_exp [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

   hd44780_ctrl_if hif();
   hd44780_ctrl_if hif2();

   hd44780_ctrl #(.CLK_KHZ(1000), .BUS_WIDTH(8), .ROWS(2), .COLS(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr(hif), .init_done(init_done),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data));

   hd44780_ctrl #(.CLK_KHZ(4000), .BUS_WIDTH(4), .ROWS(2), .COLS(16)) dut4 (
      .clk(clk4), .rst_n(rst_n2), .wr(hif2), .init_done(init_done2),
      .lcd_rs(lcd_rs2), .lcd_rw(lcd_rw2), .lcd_e(lcd_e2), .lcd_data(lcd_data2));

   initial forever #8 clk = ~clk;
   initial while (clk4_on) #2 clk4 = ~clk4;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every E pulse of the 8-bit unit as {rs, data}, plus its edge times
   always @(negedge clk) begin
      e_prev <= lcd_e;
      if (lcd_e && !e_prev) begin
         cap_q.push_back({lcd_rs, lcd_data});
         rise_cyc <= cyc;
      end
      if (!lcd_e && e_prev) fall_cyc <= cyc;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cap(input int cnt, input int budget, input string tag);
      int n = 0;
      while (cap_q.size() < cnt && n < budget) begin tick(); n++; end
      check(tag, cap_q.size(), cnt);
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (!init_done && n < budget) begin tick(); n++; end
      check(tag, init_done, 1'b1);
   endtask

   task automatic wait_ready(input int budget, input string tag);
      int n = 0;
      while (!hif.wr_ready && n < budget) begin tick(); n++; end
      check(tag, hif.wr_ready, 1'b1);
   endtask

   task automatic host_write(input logic rs, input logic [7:0] d);
      int n = 0;
      while (!hif.wr_ready && n < 4000) begin tick(); n++; end
      if (!hif.wr_ready) check("host_ready_timeout", hif.wr_ready, 1'b1);
      hif.wr_rs    = rs;
      hif.wr_data  = d;
      hif.wr_valid = 1'b1;
      @(posedge clk);
      #1;
      hif.wr_valid = 1'b0;
   endtask

   task automatic test_main();
      int rel;
      int acc;
      rel = cyc;
      // power-up quiet time and init byte order; wr_valid is held high from reset
      wait_cap(1, 16000, "pwrup_first_e");
      check("pwrup_quiet", 32'((rise_cyc - rel) >= 15000), 1);
      check("first_e_data", cap_q[0], 9'h030);
      wait_done(10000, "init_done");
      check("init_len", cap_q.size(), 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("init_byte%0d", i), cap_q[i], {1'b0, init_exp[i]});
      check("init_done_gap", cyc - fall_cyc, 40);
      // held request is taken in the first init_done cycle, exactly once
      check("held_accept_ready", hif.wr_ready, 1'b1);
      tick();
      check("held_ready_drop", hif.wr_ready, 1'b0);
      hif.wr_valid = 1'b0;
      wait_cap(9, 100, "held_byte_sent");
      check("held_byte", cap_q[8], 9'h141);
      wait_ready(200, "held_ready_back");
      repeat (20) tick();
      check("held_no_dup", cap_q.size(), 9);

      // 16 chars after clear wrap to row 1 without a host request
      cap_q.delete();
      host_write(1'b0, 8'h01);
      for (int i = 0; i < 17; i++) host_write(1'b1, 8'h61 + 8'(i));
      wait_cap(19, 200, "wrap_len");
      check("wrap_clear", cap_q[0], 9'h001);
      check("wrap_char16", cap_q[16], 9'h170);
      check("wrap_cmd_c0", cap_q[17], 9'h0C0);
      check("wrap_char17", cap_q[18], 9'h171);

      // clear busy time, then last row wraps back to row 0
      cap_q.delete();
      host_write(1'b0, 8'h01);
      acc = cyc;
      wait_ready(3000, "clear_ready_back");
      check("clear_busy_min", 32'((cyc - acc) >= 1640), 1);
      check("clear_wait_from_fall", cyc - fall_cyc, 1640);
      host_write(1'b0, 8'hC5);
      for (int i = 0; i < 11; i++) host_write(1'b1, 8'h41 + 8'(i));
      wait_cap(14, 200, "wrap0_len");
      check("wrap0_setdd", cap_q[1], 9'h0C5);
      check("wrap0_last_char", cap_q[12], 9'h14B);
      check("wrap0_cmd_80", cap_q[13], 9'h080);

      // out-of-range set-DDRAM suspends tracking: no wrap
      wait_ready(200, "wrap0_ready_back");
      cap_q.delete();
      host_write(1'b0, 8'hB0);
      for (int i = 0; i < 16; i++) host_write(1'b1, 8'h30 + 8'(i));
      wait_ready(200, "nowrap_ready_back");
      repeat (60) tick();
      check("nowrap_len", cap_q.size(), 17);

      // in-range set-DDRAM to the last column restores tracking
      cap_q.delete();
      host_write(1'b0, 8'h8F);
      host_write(1'b1, 8'h5A);
      wait_cap(3, 200, "lastcol_len");
      check("lastcol_wrap", cap_q[2], 9'h0C0);

      // async reset during E high, then full init replay
      wait_ready(200, "pre_reset_ready");
      host_write(1'b1, 8'h55);
      acc = 0;
      while (!lcd_e && acc < 50) begin tick(); acc++; end
      check("rst_saw_e_high", lcd_e, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_lcd_e", lcd_e, 1'b0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_wr_ready", hif.wr_ready, 1'b0);
      repeat (3) tick();
      cap_q.delete();
      rst_n = 1'b1;
      rel = cyc;
      wait_cap(1, 16000, "replay_first_e");
      check("replay_quiet", 32'((rise_cyc - rel) >= 15000), 1);
      check("replay_first_data", cap_q[0], 9'h030);
      wait_done(10000, "replay_init_done");
      check("replay_len", cap_q.size(), 8);
      check("replay_last", cap_q[7], 9'h00C);
   endtask

   // 4-bit bus at 4 MHz: nibble pulses, rs and the 40 us wait from the last E fall
   task automatic test_bus4();
      int n;
      int w;
      logic [3:0] nib [2];
      logic       rs [2];
      n = 0;
      while (!init_done2 && n < 90000) begin @(negedge clk4); n++; end
      check("b4_init_done", init_done2, 1'b1);
      check("b4_ready", hif2.wr_ready, 1'b1);
      hif2.wr_rs    = 1'b1;
      hif2.wr_data  = 8'h41;
      hif2.wr_valid = 1'b1;
      @(negedge clk4);
      hif2.wr_valid = 1'b0;
      for (int p = 0; p < 2; p++) begin
         n = 0;
         while (!lcd_e2 && n < 100) begin @(negedge clk4); n++; end
         nib[p] = lcd_data2;
         rs[p]  = lcd_rs2;
         w = 0;
         while (lcd_e2 && w < 100) begin @(negedge clk4); w++; end
         check($sformatf("b4_e_width%0d", p), w, 4);
      end
      n = 0;
      while (!hif2.wr_ready && n < 1000) begin @(negedge clk4); n++; end
      check("b4_nib_hi", nib[0], 4'h4);
      check("b4_rs_hi", rs[0], 1'b1);
      check("b4_nib_lo", nib[1], 4'h1);
      check("b4_rs_lo", rs[1], 1'b1);
      check("b4_ready_gap", n, 160);
      clk4_on = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      rst_n2        = 1'b0;
      hif.wr_valid  = 1'b1;
      hif.wr_rs     = 1'b1;
      hif.wr_data   = 8'h41;
      hif2.wr_valid = 1'b0;
      hif2.wr_rs    = 1'b0;
      hif2.wr_data  = 8'h00;
      repeat (3) tick();
      check("rst_e", lcd_e, 1'b0);
      check("rst_rs", lcd_rs, 1'b0);
      check("rst_rw", lcd_rw, 1'b0);
      check("rst_data", lcd_data, 8'h00);
      check("rst_done", init_done, 1'b0);
      check("rst_ready", hif.wr_ready, 1'b0);
      rst_n  = 1'b1;
      rst_n2 = 1'b1;
      fork
         test_main();
         test_bus4();
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
